data_mem_responder: RTL

Responder end of the core's data/instruction memory port: accepts the dataflow's address, store data and access size, and answers with read data after a fixed number of wait states. It holds a word-organised RAM, applies byte-lane write enables for SB/SH/SW, and returns load data right-justified (addressed byte in bits [7:0]). Sign or zero extension stays in the core's memory extender. A single-request FSM with a ready/valid handshake lets the control unit stall on memory latency.

---
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data/instruction memory responder: word RAM with byte lanes, fixed wait states, ready/valid handshake.
// Optional feature macro: DATA_MEM_RESP_ERR_EN (access-fault reporting for misaligned, reserved-size and out-of-range requests).
module data_mem_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT == 0) ? '0 : CNT_W'(WAIT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [1:0]       r_size;
  logic [31:0]      r_mem [DEPTH];

  logic              w_idle;
  logic              w_we;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic [1:0]        w_size;
  logic [1:0]        w_off;
  logic              w_byte;
  logic              w_half;
  logic              w_word;
  logic              w_misal;
  logic              w_hi;
  logic              w_err;
  logic [1:0]        w_lane;
  logic [3:0]        w_be;
  logic [31:0]       w_keep;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rdata;
  logic [31:0]       w_wdata_sh;
  logic              w_unused;

  // In IDLE the response is decoded straight from the inputs so WAIT=0 can answer on the next cycle
  assign w_idle  = (r_state == ST_IDLE);
  assign w_we    = w_idle ? req_we        : r_we;
  assign w_addr  = w_idle ? req_addr      : r_addr;
  assign w_wdata = w_idle ? req_wdata     : r_wdata;
  assign w_size  = w_idle ? req_size[1:0] : r_size;

  assign w_off   = w_addr[1:0];
  assign w_byte  = (w_size == 2'b00);
  assign w_half  = (w_size == 2'b01);
  assign w_word  = w_size[1];
  assign w_misal = (w_half & w_off[0]) | (w_word & (|w_off));
  assign w_hi    = |(w_addr >> (ADDR_W + 2));

`ifdef DATA_MEM_RESP_ERR_EN
  assign w_err    = w_misal | (w_size == 2'b11) | w_hi;
  assign w_lane   = w_off;
  assign w_unused = req_size[2];
`else
  // Size 11 decodes as word; misaligned accesses are aligned down and high bits wrap
  assign w_err    = 1'b0;
  assign w_lane   = w_word ? 2'b00 : (w_half ? {w_off[1], 1'b0} : w_off);
  assign w_unused = ^{req_size[2], w_misal, w_hi};
`endif

  assign w_be       = w_byte ? (4'b0001 << w_lane) : (w_half ? (4'b0011 << w_lane) : 4'b1111);
  assign w_keep     = w_byte ? 32'h0000_00FF : (w_half ? 32'h0000_FFFF : 32'hFFFF_FFFF);
  assign w_idx      = w_addr[ADDR_W+1:2];
  assign w_rdata    = (r_mem[w_idx] >> {w_lane, 3'b000}) & w_keep;
  assign w_wdata_sh = w_wdata << {w_lane, 3'b000};

  // Request FSM and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_we      <= req_we;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_size    <= req_size[1:0];
            req_ready <= 1'b0;
            r_cnt     <= CNT_INIT;
            if (WAIT == 0) begin
              r_state   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= w_err;
              rsp_rdata <= (w_we || w_err) ? 32'h0 : w_rdata;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= w_err;
            rsp_rdata <= (w_we || w_err) ? 32'h0 : w_rdata;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_state   <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Store commits on the edge leaving RESP; an async reset has already forced IDLE
  always_ff @(posedge clk) begin
    if ((r_state == ST_RESP) && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

endmodule
